// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants for the VGA timing generator: 640x480@60 defaults,
// an 800x600@72 alternate set, and the helpers that derive totals and widths.
package vga_timing_gen_pkg;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam bit VGA_H_POL    = 1'b0;
    localparam bit VGA_V_POL    = 1'b0;
    localparam int VGA_H_TOT    = axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOT    = axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

    // 800x600@72 uses positive sync polarity on both axes.
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 56;
    localparam int SVGA_H_SYNC   = 120;
    localparam int SVGA_H_BP     = 64;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 37;
    localparam int SVGA_V_SYNC   = 6;
    localparam int SVGA_V_BP     = 23;
    localparam bit SVGA_H_POL    = 1'b1;
    localparam bit SVGA_V_POL    = 1'b1;
    localparam int SVGA_H_TOT    = axis_total(SVGA_H_ACTIVE, SVGA_H_FP, SVGA_H_SYNC, SVGA_H_BP);
    localparam int SVGA_V_TOT    = axis_total(SVGA_V_ACTIVE, SVGA_V_FP, SVGA_V_SYNC, SVGA_V_BP);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel request/response and video output bundle of the VGA timing generator.
interface vga_timing_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10,
    parameter int CW = 4
);
    logic [XW-1:0] req_x;
    logic [YW-1:0] req_y;
    logic          req_valid;
    logic [CW-1:0] pix_r;
    logic [CW-1:0] pix_g;
    logic [CW-1:0] pix_b;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    logic          frame_start;
    logic          line_start;

    modport master (
        output req_x, req_y, req_valid, hsync, vsync, de, r, g, b, frame_start, line_start,
        input  pix_r, pix_g, pix_b
    );

    modport slave (
        input  req_x, req_y, req_valid, hsync, vsync, de, r, g, b, frame_start, line_start,
        output pix_r, pix_g, pix_b
    );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// One timing axis: counts 0..TOT-1 (active, front porch, sync, back porch)
// and decodes the active region, sync level and wrap condition.
module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP,
    parameter bit POL    = VGA_H_POL,
    localparam int TOT   = axis_total(ACTIVE, FP, SYNC, BP),
    localparam int W     = cnt_width(TOT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         active,
    output logic         sync,
    output logic         wrap
);
    // Region bounds are compared one bit wider so no bound can alias.
    localparam logic [W:0]   ACT_END  = (W+1)'(ACTIVE);
    localparam logic [W:0]   SYNC_BEG = (W+1)'(ACTIVE + FP);
    localparam logic [W:0]   SYNC_END = (W+1)'(ACTIVE + FP + SYNC);
    localparam logic [W-1:0] LAST     = W'(TOT - 1);

    logic [W-1:0] cnt_q;
    logic [W:0]   cnt_x;

    assign cnt_x  = {1'b0, cnt_q};
    assign cnt    = cnt_q;
    assign active = cnt_x < ACT_END;
    assign sync   = (cnt_x >= SYNC_BEG && cnt_x < SYNC_END) ? POL : ~POL;
    assign wrap   = inc && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (ce && inc) begin
            cnt_q <= wrap ? '0 : cnt_q + W'(1);
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: chained h/v axis counters, a stage-0 pixel request,
// and a two-stage ce pipeline aligning sync/de with the returned colour.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit H_POL    = VGA_H_POL,
    parameter bit V_POL    = VGA_V_POL,
    parameter int CW       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    vga_timing_gen_if.master vif
);
    localparam int H_TOT = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int XW    = cnt_width(H_TOT);
    localparam int YW    = cnt_width(V_TOT);

    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic          h_active, v_active, h_sync, v_sync, h_wrap, v_wrap;
    logic          req_valid;
    logic          line_head, frame_head;
    logic          hs_d, vs_d, de_d;
    logic          hsync_q, vsync_q, de_q;
    logic [CW-1:0] r_q, g_q, b_q;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL)
    ) u_h_axis (
        .clk(clk), .rst(rst), .ce(ce), .inc(1'b1),
        .cnt(h_cnt), .active(h_active), .sync(h_sync), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL)
    ) u_v_axis (
        .clk(clk), .rst(rst), .ce(ce), .inc(h_wrap),
        .cnt(v_cnt), .active(v_active), .sync(v_sync), .wrap(v_wrap)
    );

    assign req_valid     = h_active && v_active;
    assign vif.req_valid = req_valid;
    assign vif.req_x     = req_valid ? h_cnt : '0;
    assign vif.req_y     = req_valid ? v_cnt : '0;

    // line_head/frame_head flag that stage 0 sits on h=0 / (0,0); the wrap
    // outputs announce the next position, so the flags are set one ce early.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_head  <= 1'b1;
            frame_head <= 1'b1;
        end else if (ce) begin
            line_head  <= h_wrap;
            frame_head <= v_wrap;
        end
    end

    assign vif.line_start  = ce && !rst && line_head;
    assign vif.frame_start = ce && !rst && frame_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_d    <= ~H_POL;
            vs_d    <= ~V_POL;
            de_d    <= 1'b0;
            hsync_q <= ~H_POL;
            vsync_q <= ~V_POL;
            de_q    <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else if (ce) begin
            hs_d    <= h_sync;
            vs_d    <= v_sync;
            de_d    <= req_valid;
            hsync_q <= hs_d;
            vsync_q <= vs_d;
            de_q    <= de_d;
            r_q     <= de_d ? vif.pix_r : '0;
            g_q     <= de_d ? vif.pix_g : '0;
            b_q     <= de_d ? vif.pix_b : '0;
        end
    end

    assign vif.hsync = hsync_q;
    assign vif.vsync = vsync_q;
    assign vif.de    = de_q;
    assign vif.r     = r_q;
    assign vif.g     = g_q;
    assign vif.b     = b_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on an 8x6 raster with a registered pixel source.
module tb_vga_timing_gen;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vid_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.XW(3), .YW(3), .CW(4)) vif ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0), .CW(4)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .vif(vif)
    );

    vid_t exp_q[$];
    vid_t cur;
    int   checks = 0, failures = 0;
    int   h_m = 0, v_m = 0, cyc = 0;
    int   last_fs = -1, last_ls = -1, fs_per = 48, ls_per = 8;
    bit   win_en = 1'b0;
    int   de_n = 0, hs_n = 0, vs_n = 0;
    logic prev_hs = 1'b1;
    logic [3:0] pr_q = 4'd0, pg_q = 4'd0, pb_q = 4'd0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic vid_t blank_v();
        return '{hs: 1'b1, vs: 1'b1, de: 1'b0, r: 4'd0, g: 4'd0, b: 4'd0};
    endfunction

    function automatic vid_t stage0_exp();
        vid_t e;
        bit   valid;
        valid = (h_m < HA) && (v_m < VA);
        e.hs  = !(h_m >= HA + HF && h_m < HA + HF + HS);
        e.vs  = !(v_m >= VA + VF && v_m < VA + VF + VS);
        e.de  = valid;
        e.r   = valid ? 4'(h_m + 1) : 4'd0;
        e.g   = valid ? 4'(v_m + 2) : 4'd0;
        e.b   = valid ? 4'(15 - h_m) : 4'd0;
        return e;
    endfunction

    task automatic reset_model();
        h_m = 0;
        v_m = 0;
        exp_q.delete();
        exp_q.push_back(blank_v());
        cur = blank_v();
        last_fs = -1;
        last_ls = -1;
        prev_hs = 1'b1;
    endtask

    task automatic check_now(input bit ce_v, input bit rst_v);
        bit valid;
        valid = (h_m < HA) && (v_m < VA);
        chk("req_valid",   16'(vif.req_valid),   16'(valid));
        chk("req_x",       16'(vif.req_x),       16'(valid ? h_m : 0));
        chk("req_y",       16'(vif.req_y),       16'(valid ? v_m : 0));
        chk("frame_start", 16'(vif.frame_start), 16'(ce_v && !rst_v && h_m == 0 && v_m == 0));
        chk("line_start",  16'(vif.line_start),  16'(ce_v && !rst_v && h_m == 0));
        chk("hsync", 16'(vif.hsync), 16'(cur.hs));
        chk("vsync", 16'(vif.vsync), 16'(cur.vs));
        chk("de",    16'(vif.de),    16'(cur.de));
        chk("r",     16'(vif.r),     16'(cur.r));
        chk("g",     16'(vif.g),     16'(cur.g));
        chk("b",     16'(vif.b),     16'(cur.b));
        if (vif.frame_start === 1'b1) begin
            if (last_fs >= 0) chk("frame_period", 16'(cyc - last_fs), 16'(fs_per));
            last_fs = cyc;
        end
        if (vif.line_start === 1'b1) begin
            if (last_ls >= 0) chk("line_period", 16'(cyc - last_ls), 16'(ls_per));
            last_ls = cyc;
        end
        // With ce held high the sync pulse leaves the pipe 7 clocks after line_start.
        if (fs_per == 48 && last_ls >= 0 && prev_hs === 1'b1 && vif.hsync === 1'b0)
            chk("hsync_offset", 16'(cyc - last_ls), 16'd7);
        prev_hs = vif.hsync;
        if (win_en) begin
            de_n += (vif.de === 1'b1) ? 1 : 0;
            hs_n += (vif.hsync === 1'b0) ? 1 : 0;
            vs_n += (vif.vsync === 1'b0) ? 1 : 0;
        end
    endtask

    task automatic step(input bit ce_v, input bit rst_v);
        logic [2:0] xs, ys;
        @(negedge clk);
        ce        = ce_v;
        rst       = rst_v;
        vif.pix_r = pr_q;
        vif.pix_g = pg_q;
        vif.pix_b = pb_q;
        #1;
        check_now(ce_v, rst_v);
        xs = vif.req_x;
        ys = vif.req_y;
        cyc++;
        @(posedge clk);
        if (ce_v && !rst_v) begin
            exp_q.push_back(stage0_exp());
            cur  = exp_q.pop_front();
            pr_q = 4'(xs + 1);
            pg_q = 4'(ys + 2);
            pb_q = 4'(15 - xs);
            if (h_m == HT - 1) begin
                h_m = 0;
                v_m = (v_m == VT - 1) ? 0 : v_m + 1;
            end else begin
                h_m++;
            end
        end
    endtask

    initial begin
        vif.pix_r = 4'd0;
        vif.pix_g = 4'd0;
        vif.pix_b = 4'd0;
        reset_model();

        // Held in reset with ce high: blanking outputs, no pulses.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

        // Continuous ce: two warm-up clocks, then two whole frames counted.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        win_en = 1'b1;
        for (int i = 0; i < 96; i++) step(1'b1, 1'b0);
        win_en = 1'b0;
        chk("de_high_2frames",    16'(de_n), 16'd24);
        chk("hsync_low_2frames",  16'(hs_n), 16'd24);
        chk("vsync_low_2frames",  16'(vs_n), 16'd16);

        // ce every other clock: periods double, outputs hold on idle clocks.
        fs_per = 96; ls_per = 16; last_fs = -1; last_ls = -1;
        for (int i = 0; i < 200; i++) step((i % 2) == 0, 1'b0);

        // Run to h=5, v=2, then reset mid-frame.
        fs_per = 48; ls_per = 8; last_fs = -1; last_ls = -1;
        for (int i = 0; i < 60 && !(h_m == 5 && v_m == 2); i++) step(1'b1, 1'b0);
        #2;
        rst = 1'b1;
        reset_model();
        #1;
        check_now(ce, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 60; i++) step(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.
- H_POL, 0, hsync active level.
- V_POL, 0, vsync active level.
- CW, 4, bits per colour channel.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, system clock.
- rst, in, 1, reset; asynchronous, active-high.
- ce, in, 1, pixel-clock enable; the pipeline advances only when high.
- pix_r/pix_g/pix_b, in, CW each, pixel colour returned by the source.
- req_x, out, XW, requested pixel column.
- req_y, out, YW, requested pixel row.
- req_valid, out, 1, request is inside the active area.
- hsync, out, 1, horizontal sync.
- vsync, out, 1, vertical sync.
- de, out, 1, display enable.
- r/g/b, out, CW each, output colour.
- frame_start, out, 1, single-cycle pulse at the start of a frame.
- line_start, out, 1, single-cycle pulse at the start of a line.

Function
REQ-003 h_cnt SHALL count 0..H_TOT-1, where H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-004 v_cnt SHALL count 0..V_TOT-1, defined the same way from the V_ parameters.
REQ-005 Both counters SHALL update only on clk edges where ce=1.
REQ-006 h_cnt SHALL wrap to 0 after H_TOT-1, and v_cnt SHALL increment on that same edge.
REQ-007 v_cnt SHALL wrap to 0 when both counters are at their maximum.
REQ-008 Each line SHALL be ordered active, front porch, sync, back porch; frames SHALL use the same order vertically.
REQ-009 Stage 0 (combinational from the counters) SHALL drive:
- req_valid = (h_cnt<H_ACTIVE) and (v_cnt<V_ACTIVE).
- req_x = h_cnt and req_y = v_cnt when req_valid, otherwise 0.
REQ-010 The pixel source SHALL return colour for a request one ce-cycle later; pix_* SHALL be sampled on the next ce edge.
REQ-011 hsync, vsync and de SHALL be registered and delayed by exactly 2 ce-cycles relative to stage 0, so they align with r/g/b.
REQ-012 r/g/b SHALL be registered: pix_* when the delayed de is high, otherwise 0.
REQ-013 hsync SHALL equal H_POL when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], otherwise ~H_POL (before the 2-cycle delay).
REQ-014 vsync SHALL follow the same rule using v_cnt and the V_ parameters.
REQ-015 frame_start SHALL be high for exactly one clk cycle: the ce cycle on which stage 0 has h_cnt=0 and v_cnt=0.
REQ-016 line_start SHALL follow the same rule whenever h_cnt=0.
REQ-017 While ce=0, every register and every output SHALL hold its value.
REQ-018 When ce=0, frame_start and line_start SHALL be 0.
REQ-019 Widths SHALL be XW=clog2(H_TOT) and YW=clog2(V_TOT); all comparisons SHALL be unsigned and free of overflow.

Reset
REQ-020 While rst=1 (asynchronous), the block SHALL hold:
- h_cnt=0, v_cnt=0.
- hsync=~H_POL, vsync=~V_POL.
- de=0, r/g/b=0.
- frame_start=0, line_start=0.
- The whole delay pipeline cleared to the blanking state.
REQ-021 After rst deasserts, the first ce edge SHALL advance from (0,0).
REQ-022 frame_start SHALL pulse on the first ce cycle after reset.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately, with no partial line completed.

Structure
REQ-024 A shared package SHALL hold the timing defaults for 640x480@60, the totals derivation, and a clog2-based width function.
REQ-025 The package SHALL also hold an 800x600@72 alternate constant set.
REQ-026 One sub-module SHALL exist: vga_axis_counter (parametrised ACTIVE/FP/SYNC/BP/POL).
REQ-027 vga_axis_counter SHALL have inputs ce and inc, and outputs cnt, active, sync and wrap.
REQ-028 The top level SHALL instantiate vga_axis_counter twice, chaining the horizontal wrap output into the vertical inc input.

Verification
REQ-029 The bench SHALL run with a small timing set: H=4/1/2/1 (H_TOT=8), V=3/1/1/1 (V_TOT=6), ce=1, H_POL=V_POL=0.
REQ-030 Frame period: 48 clocks between frame_start pulses; line_start every 8 clocks; exactly 12 de-high cycles per frame.
REQ-031 Alignment: pix_r=req_x+1 fed one cycle after each request; r SHALL read 1,2,3,4 on each active line, and 0 whenever de=0.
REQ-032 Sync: hsync low for exactly 2 clocks per line, starting 7 clocks after line_start; vsync low for 8 clocks per frame.
REQ-033 ce=1 every other clock: the frame period SHALL double to 96 clocks; all outputs SHALL hold on ce=0 cycles; no pulse occurs when ce=0.
REQ-034 rst pulsed at h_cnt=5, v_cnt=2: outputs SHALL immediately show the REQ-020 values; frame_start SHALL pulse on the first ce after release; a full 48-clock frame SHALL follow.
